reg_file_sb: RTL

Parametrised general-purpose register file with an integrated scoreboard, replacing the fixed set of eight individually-loaded 16-bit registers in the datapath. It provides one synchronous write port, two combinational read ports with optional write-to-read bypass, and per-register pending bits. The pending bits let the control unit stall on read-after-write and write-after-write hazards when results arrive late, for example from memory or a multi-cycle ALU. It sits between the bus/ALU result mux and the ALU operand inputs.

---
 rtl/reg_file_sb.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Register file with per-register pending bits for late-arriving results.
// One write port, two combinational read ports with optional same-cycle bypass.

module reg_file_sb_cell #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pend
);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (wr) q <= d;
      // A new producer issued this cycle owns the register even if an older result lands now.
      if (set)     pend <= 1'b1;
      else if (wr) pend <= 1'b0;
    end
  end
endmodule

module reg_file_sb #(
  parameter  int WIDTH  = 16,
  parameter  int NREGS  = 8,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] Data_in,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  input  logic             SR1_used,
  input  logic             SR2_used,
  input  logic             Issue,
  input  logic [AW-1:0]    Issue_DR,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic [NREGS-1:0] Busy,
  output logic             Stall
);
  localparam bit BYP = (BYPASS != 0);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            pend;
  logic [NREGS-1:0]            sel1, sel2, seli, seld, wr_hit, set_hit;
  logic [WIDTH-1:0]            rd1, rd2;
  logic                        issue_ok, raw1, raw2, waw, clr1, clr2;

  // One-hot decodes; out-of-range addresses decode to all-zero, so they read 0,
  // never look pending and never write.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(i);
    assign sel1[i]    = (SR1 == IDX);
    assign sel2[i]    = (SR2 == IDX);
    assign seli[i]    = (Issue_DR == IDX);
    assign seld[i]    = (DR == IDX);
    assign wr_hit[i]  = LD_REG & seld[i];
    assign set_hit[i] = issue_ok & seli[i];

    reg_file_sb_cell #(.WIDTH(WIDTH)) u_cell (
      .Clk   (Clk),
      .Reset (Reset),
      .wr    (wr_hit[i]),
      .set   (set_hit[i]),
      .d     (Data_in),
      .q     (regs[i]),
      .pend  (pend[i])
    );
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel1[i]) rd1 = regs[i];
      if (sel2[i]) rd2 = regs[i];
    end
  end

  assign SR1_OUT = (BYP && LD_REG && (DR == SR1) && |sel1) ? Data_in : rd1;
  assign SR2_OUT = (BYP && LD_REG && (DR == SR2) && |sel2) ? Data_in : rd2;
  assign Busy    = pend;

  // Without bypass the reader cannot see this cycle's writeback, so it keeps stalling.
  assign clr1     = BYP & LD_REG & (DR == SR1);
  assign clr2     = BYP & LD_REG & (DR == SR2);
  assign raw1     = SR1_used & |(pend & sel1) & ~clr1;
  assign raw2     = SR2_used & |(pend & sel2) & ~clr2;
  assign waw      = Issue & |(pend & seli) & ~(LD_REG & (DR == Issue_DR));
  assign Stall    = (Issue & (raw1 | raw2)) | waw;
  assign issue_ok = Issue & ~Stall;
endmodule
